// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult: sequential radix-4 Booth multiplier, one digit per clock
module booth_r4_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int NDIG = WIDTH / 2 + 1;
    localparam int CW = $clog2(NDIG);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
    logic [1:0]         state;
    logic [WIDTH+1:0]   ax, mag, pp;
    logic [WIDTH+2:0]   sr;
    logic [2*WIDTH-1:0] acc, acc_nx, ppx;
    logic [CW-1:0]      cnt;
    logic [2:0]         d;
    logic               neg;
    assign d = sr[2:0];
    // negative digits add ~mag here and the +1 rides along with the shifted term
    always_comb begin
        mag = (d == 3'b011 || d == 3'b100) ? {ax[WIDTH:0], 1'b0} :
              (d == 3'b000 || d == 3'b111) ? '0 : ax;
        neg = d[2] & ~&d;
        pp = neg ? ~mag : mag;
        ppx = {{(WIDTH-2){pp[WIDTH+1]}}, pp};
        acc_nx = acc + ((ppx + {{(2*WIDTH-1){1'b0}}, neg}) << {cnt, 1'b0});
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ax <= '0;
            sr <= '0;
            acc <= '0;
            cnt <= '0;
            product <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                ax <= {{2{is_signed & a[WIDTH-1]}}, a};
                sr <= {{2{is_signed & b[WIDTH-1]}}, b, 1'b0};
                acc <= '0;
                cnt <= '0;
                state <= CALC;
            end
        end else if (state == CALC) begin
            acc <= acc_nx;
            sr <= sr >> 2;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(NDIG - 1)) begin
                product <= acc_nx;
                state <= DONE;
            end
        end else if (state == DONE) begin
            if (out_ready) state <= IDLE;
        end else begin
            state <= IDLE;
        end
    end
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb_booth_r4_seq_mult: scoreboard bench for 8- and 16-bit instances
module tb_booth_r4_seq_mult;
    typedef struct {logic [31:0] p; int t;} exp_t;
    logic clk = 0, rst = 1, ordy = 1;
    logic v8 = 0, s8 = 0, rdy8, ov8, busy8;
    logic [7:0] a8 = 0, b8 = 0;
    logic [15:0] prod8;
    logic v16 = 0, s16 = 0, rdy16, ov16, busy16;
    logic [15:0] a16 = 0, b16 = 0;
    logic [31:0] prod16;
    int cyc = 0, checks = 0, errors = 0, last_acc = 0;
    exp_t q8[$], q16[$];
    bit shown8 = 0, shown16 = 0;

    booth_r4_seq_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
        .is_signed(s8), .a(a8), .b(b8), .out_valid(ov8), .out_ready(ordy), .product(prod8), .busy(busy8));
    booth_r4_seq_mult #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16),
        .is_signed(s16), .a(a16), .b(b16), .out_valid(ov16), .out_ready(ordy), .product(prod16), .busy(busy16));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", n, act, exp, cyc);
        end
    endtask

    // drive operands, wait for acceptance, push expectation; in_valid stays high
    task automatic issue(input bit w16, input bit s, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input bit push);
        int t = 0;
        @(negedge clk);
        if (w16) begin v16 = 1; s16 = s; a16 = a; b16 = b; end
        else begin v8 = 1; s8 = s; a8 = a[7:0]; b8 = b[7:0]; end
        while (!(w16 ? rdy16 : rdy8) && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        last_acc = cyc;
        if (push && w16) q16.push_back('{exp, cyc});
        else if (push) q8.push_back('{exp, cyc});
    endtask

    task automatic drain();
        int t = 0;
        while ((q8.size() != 0 || q16.size() != 0) && t < 200) begin @(negedge clk); t++; end
        chk("drain_timeout", t >= 200, 0);
    endtask

    always @(negedge clk) if (!rst) begin
        chk("rdy8_busy", busy8 & rdy8, 0);
        if (ov8) begin
            if (q8.size() == 0) chk("spurious8", 1, 0);
            else begin
                if (!shown8) chk("lat8", cyc - q8[0].t, 5);
                shown8 = 1;
                chk("prod8", prod8, q8[0].p[15:0]);
                if (ordy) begin void'(q8.pop_front()); shown8 = 0; end
            end
        end
    end

    always @(negedge clk) if (!rst) begin
        chk("rdy16_busy", busy16 & rdy16, 0);
        if (ov16) begin
            if (q16.size() == 0) chk("spurious16", 1, 0);
            else begin
                if (!shown16) chk("lat16", cyc - q16[0].t, 9);
                shown16 = 1;
                chk("prod16", prod16, q16[0].p);
                if (ordy) begin void'(q16.pop_front()); shown16 = 0; end
            end
        end
    end

    initial begin
        logic [15:0] ra, rb;
        logic [31:0] sa, sb;
        bit rs;
        int t0, t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", rdy8, 1);
        chk("rst_out_valid", ov8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_product", prod8, 0);
        rst = 0;
        // basic unsigned/signed vectors and zero boundaries
        issue(0, 0, 16'hFF, 16'hFF, 32'hFE01, 1); v8 = 0;
        issue(0, 1, 16'h80, 16'h80, 32'h4000, 1); v8 = 0;
        issue(0, 1, 16'hFF, 16'h01, 32'hFFFF, 1); v8 = 0;
        issue(0, 1, 16'h7F, 16'h80, 32'hC080, 1); v8 = 0;
        issue(0, 0, 16'hFF, 16'h01, 32'h00FF, 1); v8 = 0;
        issue(0, 0, 16'h80, 16'h80, 32'h4000, 1); v8 = 0;
        issue(0, 1, 16'hFD, 16'h07, 32'hFFEB, 1); v8 = 0;
        issue(0, 0, 16'h0D, 16'h0B, 32'h008F, 1); v8 = 0;
        issue(0, 0, 16'h00, 16'hAB, 32'h0000, 1); v8 = 0;
        issue(0, 1, 16'h5A, 16'h00, 32'h0000, 1); v8 = 0;
        drain();
        // stall in DONE with in_valid pulses that must be ignored
        @(posedge clk); #1 ordy = 0;
        issue(0, 0, 16'h12, 16'h34, 32'h03A8, 1); v8 = 0;
        t = 0;
        while (!ov8 && t < 20) begin @(negedge clk); t++; end
        chk("stall_reach_done", ov8, 1);
        repeat (6) begin @(negedge clk); v8 = ~v8; a8 = 8'h77; b8 = 8'h99; end
        v8 = 0;
        @(posedge clk); #1 ordy = 1;
        drain();
        // reset on the third CALC cycle drops the operation
        issue(0, 0, 16'h21, 16'h03, 32'h0, 0); v8 = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("abort_in_ready", rdy8, 1);
        chk("abort_out_valid", ov8, 0);
        chk("abort_product", prod8, 0);
        rst = 0;
        issue(0, 0, 16'h03, 16'h05, 32'h000F, 1); v8 = 0;
        drain();
        // back-to-back with in_valid held high
        issue(0, 0, 16'h0F, 16'h0F, 32'h00E1, 1);
        t0 = last_acc;
        issue(0, 1, 16'h9C, 16'h05, 32'hFE0C, 1); v8 = 0;
        chk("b2b_spacing", last_acc - t0, 7);
        drain();
        // 16-bit instance: boundaries then random sweep against a*b
        issue(1, 1, 16'h8000, 16'h8000, 32'h40000000, 1); v16 = 0;
        issue(1, 0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1); v16 = 0;
        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            sa = {{16{rs & ra[15]}}, ra};
            sb = {{16{rs & rb[15]}}, rb};
            issue(1, rs, ra, rb, sa * sb, 1); v16 = 0;
        end
        drain();
        chk("q8_empty", q8.size(), 0);
        chk("q16_empty", q16.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
